// File: rtl/qea_host_sequencer.sv
// Host-side job sequencer for the QEA: loads gate context, clears the state RAM
// to |0...0>, starts the engine, times it, and streams the final state vector out.
module qea_host_sequencer #(
    parameter int PE_NUM                  = 4,
    parameter int PE_NUM_WIDTH            = 2,
    parameter int DATA_WIDTH              = 32,
    parameter int STATE_DATA_WIDTH        = 64,
    parameter int STATE_ADDR_WIDTH        = 16,
    parameter int GATE_CONTEXT_DATA_WIDTH = 64,
    parameter int GATE_CONTEXT_ADDR_WIDTH = 16,
    parameter int MAX_QBIT_WIDTH          = 6,
    parameter logic [DATA_WIDTH-1:0] ONE_VALUE = 32'h40000000
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 i_run,
    input  logic [MAX_QBIT_WIDTH-1:0]            i_qbit_num,
    input  logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   i_ins_num,
    input  logic                                 s_ctx_valid,
    input  logic [GATE_CONTEXT_DATA_WIDTH-1:0]   s_ctx_data,
    output logic                                 s_ctx_ready,
    output logic                                 m_state_valid,
    output logic [PE_NUM*STATE_DATA_WIDTH-1:0]   m_state_data,
    output logic                                 m_state_last,
    input  logic                                 m_state_ready,
    output logic                                 o_busy,
    output logic                                 o_done,
    output logic                                 o_error,
    output logic [31:0]                          o_exec_cycles,
    output logic                                 o_qea_start,
    output logic [MAX_QBIT_WIDTH-1:0]            o_qea_qbit_num,
    output logic                                 o_ctx_en,
    output logic                                 o_ctx_wea,
    output logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   o_ctx_addr,
    output logic [GATE_CONTEXT_DATA_WIDTH-1:0]   o_ctx_data,
    output logic [PE_NUM-1:0]                    o_state_ena,
    output logic [PE_NUM-1:0]                    o_state_wea,
    output logic [STATE_ADDR_WIDTH-1:0]          o_state_addra,
    output logic [PE_NUM*STATE_DATA_WIDTH-1:0]   o_state_dina,
    input  logic                                 i_qea_complete,
    input  logic [PE_NUM*STATE_DATA_WIDTH-1:0]   i_qea_state_dout
);

    localparam int ROW_W  = PE_NUM * STATE_DATA_WIDTH;
    localparam int RCNT_W = STATE_ADDR_WIDTH + 1;
    localparam logic [MAX_QBIT_WIDTH-1:0] QMIN = MAX_QBIT_WIDTH'(PE_NUM_WIDTH);
    localparam logic [MAX_QBIT_WIDTH-1:0] QMAX = MAX_QBIT_WIDTH'(STATE_ADDR_WIDTH + PE_NUM_WIDTH);
    // Amplitude 0 lives in the real half of the most significant lane of row 0.
    localparam logic [ROW_W-1:0] ROW0 = {ONE_VALUE, {(ROW_W-DATA_WIDTH){1'b0}}};

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD_CTX, S_INIT_ST, S_START, S_WAIT_CMP,
        S_RD_ISSUE, S_RD_WAIT, S_RD_OUT, S_DONE
    } state_t;

    state_t                               r_state, w_next;
    logic [MAX_QBIT_WIDTH-1:0]            r_qbit;
    logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   r_ins;
    logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   r_beat;
    logic [RCNT_W-1:0]                    r_rows;
    logic [RCNT_W-1:0]                    r_row;
    logic [31:0]                          r_cnt;
    logic [31:0]                          r_exec;
    logic                                 r_ctx_en;
    logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   r_ctx_addr;
    logic [GATE_CONTEXT_DATA_WIDTH-1:0]   r_ctx_data;
    logic [ROW_W-1:0]                     r_rd_data;
    logic                                 r_error;

    logic w_run_ok, w_accept, w_last_beat, w_last_row;

    assign w_run_ok    = (i_qbit_num >= QMIN) && (i_qbit_num <= QMAX);
    assign w_accept    = (r_state == S_IDLE) && i_run && w_run_ok;
    assign w_last_beat = (r_beat == r_ins - GATE_CONTEXT_ADDR_WIDTH'(1));
    assign w_last_row  = (r_row == r_rows - RCNT_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next        = r_state;
        s_ctx_ready   = 1'b0;
        o_qea_start   = 1'b0;
        o_state_ena   = '0;
        o_state_wea   = '0;
        o_state_addra = '0;
        o_state_dina  = '0;
        m_state_valid = 1'b0;
        m_state_last  = 1'b0;
        o_done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_next = (i_ins_num == '0) ? S_INIT_ST : S_LOAD_CTX;
            end
            S_LOAD_CTX: begin
                s_ctx_ready = 1'b1;
                if (s_ctx_valid && w_last_beat) w_next = S_INIT_ST;
            end
            S_INIT_ST: begin
                o_state_ena   = '1;
                o_state_wea   = '1;
                o_state_addra = r_row[STATE_ADDR_WIDTH-1:0];
                o_state_dina  = (r_row == '0) ? ROW0 : '0;
                if (w_last_row) w_next = S_START;
            end
            S_START: begin
                o_qea_start = 1'b1;
                w_next      = S_WAIT_CMP;
            end
            S_WAIT_CMP: begin
                if (i_qea_complete) w_next = S_RD_ISSUE;
            end
            S_RD_ISSUE: begin
                o_state_ena   = '1;
                o_state_addra = r_row[STATE_ADDR_WIDTH-1:0];
                w_next        = S_RD_WAIT;
            end
            S_RD_WAIT: w_next = S_RD_OUT;
            S_RD_OUT: begin
                m_state_valid = 1'b1;
                m_state_last  = w_last_row;
                if (m_state_ready) w_next = w_last_row ? S_DONE : S_RD_ISSUE;
            end
            S_DONE: begin
                o_done = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_qbit     <= '0;
            r_ins      <= '0;
            r_beat     <= '0;
            r_rows     <= '0;
            r_row      <= '0;
            r_cnt      <= '0;
            r_exec     <= '0;
            r_ctx_en   <= 1'b0;
            r_ctx_addr <= '0;
            r_ctx_data <= '0;
            r_rd_data  <= '0;
            r_error    <= 1'b0;
        end else begin
            r_error  <= (r_state == S_IDLE) && i_run && !w_run_ok;
            r_ctx_en <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_qbit <= i_qbit_num;
                        r_ins  <= i_ins_num;
                        r_rows <= RCNT_W'(1) << (i_qbit_num - QMIN);
                        r_beat <= '0;
                        r_row  <= '0;
                    end
                end
                S_LOAD_CTX: begin
                    if (s_ctx_valid) begin
                        r_ctx_en   <= 1'b1;
                        r_ctx_addr <= r_beat;
                        r_ctx_data <= s_ctx_data;
                        r_beat     <= r_beat + GATE_CONTEXT_ADDR_WIDTH'(1);
                    end
                end
                S_INIT_ST:  r_row <= w_last_row ? '0 : r_row + RCNT_W'(1);
                S_START:    r_cnt <= 32'd1;
                S_WAIT_CMP: begin
                    r_cnt <= r_cnt + 32'd1;
                    if (i_qea_complete) r_exec <= r_cnt;
                end
                S_RD_WAIT:  r_rd_data <= i_qea_state_dout;
                S_RD_OUT: begin
                    if (m_state_ready) r_row <= r_row + RCNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign o_busy         = (r_state != S_IDLE);
    assign o_error        = r_error;
    assign o_exec_cycles  = r_exec;
    assign o_qea_qbit_num = r_qbit;
    assign o_ctx_en       = r_ctx_en;
    assign o_ctx_wea      = r_ctx_en;
    assign o_ctx_addr     = r_ctx_addr;
    assign o_ctx_data     = r_ctx_data;
    assign m_state_data   = r_rd_data;

endmodule

// File: tb/tb_qea_host_sequencer.sv
// Directed bench for qea_host_sequencer with a behavioural QEA (fixed 100-cycle
// run time, patterned state RAM) and negedge monitors logging every strobe.
module tb_qea_host_sequencer;

    localparam int RW = 256;
    localparam logic [RW-1:0] ROW0 = {64'h40000000_00000000, 192'h0};

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            i_run = 1'b0;
    logic [5:0]      i_qbit_num = '0;
    logic [15:0]     i_ins_num = '0;
    logic            s_ctx_valid = 1'b0;
    logic [63:0]     s_ctx_data = '0;
    logic            s_ctx_ready;
    logic            m_state_valid;
    logic [RW-1:0]   m_state_data;
    logic            m_state_last;
    logic            m_state_ready = 1'b0;
    logic            o_busy, o_done, o_error;
    logic [31:0]     o_exec_cycles;
    logic            o_qea_start;
    logic [5:0]      o_qea_qbit_num;
    logic            o_ctx_en, o_ctx_wea;
    logic [15:0]     o_ctx_addr;
    logic [63:0]     o_ctx_data;
    logic [3:0]      o_state_ena, o_state_wea;
    logic [15:0]     o_state_addra;
    logic [RW-1:0]   o_state_dina;
    logic            i_qea_complete;
    logic [RW-1:0]   i_qea_state_dout = '0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    qea_host_sequencer dut (
        .clk(clk), .rst_n(rst_n), .i_run(i_run), .i_qbit_num(i_qbit_num), .i_ins_num(i_ins_num),
        .s_ctx_valid(s_ctx_valid), .s_ctx_data(s_ctx_data), .s_ctx_ready(s_ctx_ready),
        .m_state_valid(m_state_valid), .m_state_data(m_state_data), .m_state_last(m_state_last),
        .m_state_ready(m_state_ready), .o_busy(o_busy), .o_done(o_done), .o_error(o_error),
        .o_exec_cycles(o_exec_cycles), .o_qea_start(o_qea_start), .o_qea_qbit_num(o_qea_qbit_num),
        .o_ctx_en(o_ctx_en), .o_ctx_wea(o_ctx_wea), .o_ctx_addr(o_ctx_addr), .o_ctx_data(o_ctx_data),
        .o_state_ena(o_state_ena), .o_state_wea(o_state_wea), .o_state_addra(o_state_addra),
        .o_state_dina(o_state_dina), .i_qea_complete(i_qea_complete), .i_qea_state_dout(i_qea_state_dout)
    );

    task automatic check_val(input string tag, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [RW-1:0] pat(input int r);
        logic [RW-1:0] v;
        v = '0;
        for (int l = 0; l < 4; l++)
            v[l*64 +: 64] = {16'hBEEF, 8'(r), 8'(l), 32'h1234_0000 + 32'(r*4 + l)};
        return v;
    endfunction

    function automatic logic [63:0] cword(input int k);
        return {32'hC7C0_0000 + 32'(k), ~32'(k)};
    endfunction

    // QEA model: complete rises 100 cycles after start; results replace the RAM at start.
    int qcnt;
    logic [RW-1:0] mem [0:63];
    assign i_qea_complete = (qcnt >= 100);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)                          qcnt <= 0;
        else if (o_qea_start)                qcnt <= 1;
        else if (qcnt != 0 && qcnt < 100000) qcnt <= qcnt + 1;
    end

    always @(posedge clk) begin
        if (o_qea_start)
            for (int r = 0; r < 64; r++) mem[r] <= pat(r);
        if (o_state_ena == 4'hF && o_state_wea == 4'h0)
            i_qea_state_dout <= mem[o_state_addra[5:0]];
    end

    int ctx_n = 0, init_n = 0, rds_n = 0, hs_n = 0, start_n = 0, done_n = 0, err_n = 0;
    logic [15:0]   ctx_a  [0:1023];
    logic [63:0]   ctx_d  [0:1023];
    logic [15:0]   init_a [0:63];
    logic [RW-1:0] init_d [0:63];
    logic [15:0]   rds_a  [0:63];
    logic [RW-1:0] hs_d   [0:63];
    logic          hs_l   [0:63];

    always @(negedge clk) begin
        if (rst_n) begin
            if (o_ctx_en && o_ctx_wea && ctx_n < 1024) begin
                ctx_a[ctx_n] <= o_ctx_addr;
                ctx_d[ctx_n] <= o_ctx_data;
                ctx_n        <= ctx_n + 1;
            end
            if (o_state_ena == 4'hF && o_state_wea == 4'hF && init_n < 64) begin
                init_a[init_n] <= o_state_addra;
                init_d[init_n] <= o_state_dina;
                init_n         <= init_n + 1;
            end
            if (o_state_ena == 4'hF && o_state_wea == 4'h0 && rds_n < 64) begin
                rds_a[rds_n] <= o_state_addra;
                rds_n        <= rds_n + 1;
            end
            if (m_state_valid && m_state_ready && hs_n < 64) begin
                hs_d[hs_n] <= m_state_data;
                hs_l[hs_n] <= m_state_last;
                hs_n       <= hs_n + 1;
            end
            if (o_qea_start) start_n <= start_n + 1;
            if (o_done)      done_n  <= done_n + 1;
            if (o_error)     err_n   <= err_n + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outputs_zero(input string nm);
        check_val({nm, "_m_data"}, m_state_data, '0);
        check_val({nm, "_dina"}, o_state_dina, '0);
        check_val({nm, "_ctrl"}, RW'({s_ctx_ready, m_state_valid, m_state_last, o_busy, o_done, o_error,
                  o_exec_cycles, o_qea_start, o_qea_qbit_num, o_ctx_en, o_ctx_wea, o_ctx_addr,
                  o_ctx_data, o_state_ena, o_state_wea, o_state_addra}), '0);
    endtask

    // Runs one full job from a drive point; stall holds ready low 5 cycles on row 3.
    task automatic run_job(input logic [5:0] qb, input int ins, input bit gap, input bit poke,
                           input bit stall, input string nm);
        int rows = 1 << (qb - 6'd2);
        int cb = ctx_n, ib = init_n, rb = rds_n, hb = hs_n, sb = start_n, db = done_n, eb = err_n;
        int k, t, bad, rs;
        logic [RW-1:0] snap;

        i_qbit_num = qb; i_ins_num = 16'(ins); i_run = 1'b1;
        tick();
        i_run = 1'b0;

        k = 0; t = 0;
        while (k < ins && t < 2000) begin
            s_ctx_valid = !(gap && t[0]);
            s_ctx_data  = cword(k);
            @(negedge clk);
            if (s_ctx_valid && s_ctx_ready) k++;
            tick();
            t++;
        end
        check_val({nm, "_ctx_sent"}, RW'(k), RW'(ins));
        s_ctx_valid = 1'b1;
        s_ctx_data  = cword(ins);

        t = 0;
        while (start_n == sb && t < 1000) begin
            @(negedge clk);
            t++;
        end
        tick();
        s_ctx_valid = 1'b0;
        @(negedge clk);
        check_val({nm, "_qbit_out"}, RW'(o_qea_qbit_num), RW'(qb));
        check_val({nm, "_busy_wait"}, RW'(o_busy), RW'(1));
        tick();
        if (poke) begin
            i_qbit_num = 6'd1; i_run = 1'b1;
            tick();
            i_run = 1'b0; i_qbit_num = qb;
        end

        for (int r = 0; r < rows; r++) begin
            t = 0;
            @(negedge clk);
            while (!m_state_valid && t < 500) begin
                @(negedge clk);
                t++;
            end
            check_val({nm, "_rd_valid"}, RW'(m_state_valid), RW'(1));
            if (stall && r == 3) begin
                snap = m_state_data;
                rs   = rds_n;
                repeat (5) begin
                    @(negedge clk);
                    check_val({nm, "_stall_valid"}, RW'(m_state_valid), RW'(1));
                    check_val({nm, "_stall_data"}, m_state_data, snap);
                end
                check_val({nm, "_stall_no_rd"}, RW'(rds_n), RW'(rs));
            end
            @(posedge clk); #1 m_state_ready = 1'b1;
            @(negedge clk);
            @(posedge clk); #1 m_state_ready = 1'b0;
        end

        t = 0;
        while (done_n == db && t < 50) begin
            @(negedge clk);
            t++;
        end
        repeat (3) @(negedge clk);

        check_val({nm, "_ctx_n"}, RW'(ctx_n - cb), RW'(ins));
        bad = 0;
        for (int i = 0; i < ins && cb + i < 1024; i++)
            if (ctx_a[cb+i] !== 16'(i) || ctx_d[cb+i] !== cword(i)) bad++;
        check_val({nm, "_ctx_seq"}, RW'(bad), '0);
        check_val({nm, "_init_n"}, RW'(init_n - ib), RW'(rows));
        bad = 0;
        for (int i = 0; i < rows && ib + i < 64; i++)
            if (init_a[ib+i] !== 16'(i) || init_d[ib+i] !== ((i == 0) ? ROW0 : '0)) bad++;
        check_val({nm, "_init_rows"}, RW'(bad), '0);
        check_val({nm, "_init_row0"}, init_d[ib], ROW0);
        check_val({nm, "_start_n"}, RW'(start_n - sb), RW'(1));
        check_val({nm, "_exec"}, RW'(o_exec_cycles), RW'(100));
        check_val({nm, "_rd_n"}, RW'(rds_n - rb), RW'(rows));
        check_val({nm, "_hs_n"}, RW'(hs_n - hb), RW'(rows));
        for (int i = 0; i < rows && hb + i < 64; i++) begin
            if (rds_a[rb+i] !== 16'(i))
                check_val({nm, "_rd_addr"}, RW'(rds_a[rb+i]), RW'(i));
            check_val({nm, "_row_data"}, hs_d[hb+i], pat(i));
            check_val({nm, "_row_last"}, RW'(hs_l[hb+i]), RW'(i == rows - 1));
        end
        check_val({nm, "_done_n"}, RW'(done_n - db), RW'(1));
        check_val({nm, "_err_n"}, RW'(err_n - eb), '0);
        check_val({nm, "_busy_end"}, RW'(o_busy), '0);
        tick();
    endtask

    initial begin
        int eb, t, cb;

        #2;
        check_outputs_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        eb = err_n;
        i_qbit_num = 6'd1; i_run = 1'b1;
        tick();
        i_run = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check_val("err_busy_lo", RW'(o_busy), '0);
        end
        check_val("err_low_qbit", RW'(err_n - eb), RW'(1));
        tick();
        i_qbit_num = 6'd19; i_run = 1'b1;
        tick();
        i_run = 1'b0;
        repeat (3) @(negedge clk);
        check_val("err_high_qbit", RW'(err_n - eb), RW'(2));
        check_val("err_busy_hi", RW'(o_busy), '0);
        tick();

        run_job(6'd5, 203, 1'b0, 1'b1, 1'b1, "jobA");
        run_job(6'd5, 203, 1'b1, 1'b0, 1'b0, "jobB");
        run_job(6'd2, 1, 1'b0, 1'b0, 1'b0, "jobE");

        cb = ctx_n;
        i_qbit_num = 6'd5; i_ins_num = 16'd0; i_run = 1'b1;
        tick();
        i_run = 1'b0;
        t = 0;
        @(negedge clk);
        while (!(o_state_wea == 4'hF && o_state_addra == 16'd4) && t < 50) begin
            @(negedge clk);
            t++;
        end
        check_val("rst_at_row4", RW'(o_state_addra), RW'(4));
        check_val("rst_no_ctx", RW'(ctx_n - cb), '0);
        #2 rst_n = 1'b0;
        #1;
        check_outputs_zero("midjob_rst");
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        run_job(6'd3, 4, 1'b0, 1'b0, 1'b0, "jobD");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
